layers_flash_mux: RTL and testbench
===================================

// Module: layers_flash_mux
// PURPOSE
//  Final pixel-colour stage, directly upstream of the VGA controller's RGBIn input.
//  Picks one colour per pixel from NUM_LAYERS object draw requests, by fixed priority,
//  with a transparent colour key; falls back to the background colour when no layer wins.
//  Adds a frame-synchronous "goal flash" effect: the background blinks to FLASH_RGB for a
//  set number of on/off phases, triggered by a single-cycle game-logic pulse.
// PARAMETERS
//  NUM_LAYERS    4      number of object layers; index 0 is highest priority
//  BLINK_FRAMES  8      frames per ON phase and per OFF phase of the flash (>=1)
//  FLASH_COUNT   3      number of ON phases per flash sequence (>=1)
//  FLASH_RGB     8'h1F  background colour during ON phases; must differ from TRANSPARENT_RGB
// PORTS
//  clk              in   1              pixel clock, same clock as the VGA controller
//  resetN           in   1              asynchronous, active-low reset
//  startOfFrame     in   1              single-cycle pulse from the VGA controller at frame start
//  flash_req        in   1              single-cycle pulse that requests a flash sequence
//  layer_dr         in   NUM_LAYERS     per-layer drawing request for the current pixel
//  layer_rgb        in   NUM_LAYERS x 8 per-layer 8-bit packed colour
//  background_rgb   in   8              background colour for the current pixel
//  RGBOut           out  8              registered pixel colour, connected to RGBIn
//  flash_active     out  1              high in FLASH_ON and FLASH_OFF states
// BEHAVIOUR
//  Reset: RGBOut=8'h00, flash_active=0, FSM=IDLE, frame and phase counters=0.
//   Reset takes effect immediately, including mid-sequence.
//  Mux (latency 1 clk):
//   - Layer i wins when layer_dr[i]=1 and layer_rgb[i]!=TRANSPARENT_RGB.
//   - The lowest winning index is registered into RGBOut.
//   - With no winner, RGBOut <= (state==FLASH_ON) ? FLASH_RGB : background_rgb.
//   - Layers are drawn over the flash unchanged.
//  Flash FSM, states {IDLE, ARMED, FLASH_ON, FLASH_OFF}:
//   - IDLE:  flash_req -> ARMED.
//   - ARMED: on startOfFrame -> FLASH_ON; frame_cnt <= BLINK_FRAMES-1; phase_cnt <= FLASH_COUNT-1.
//   - FLASH_ON / FLASH_OFF: only startOfFrame advances state.
//     - frame_cnt!=0: decrement frame_cnt.
//     - frame_cnt==0 in FLASH_ON  -> FLASH_OFF, frame_cnt reloaded.
//     - frame_cnt==0 in FLASH_OFF -> IDLE if phase_cnt==0; otherwise FLASH_ON,
//       decrement phase_cnt, reload frame_cnt.
//   - Every state change happens at frame boundaries only, so a frame never tears.
//   - The new state affects the pixel mux in the same cycle it is entered, so RGBOut
//     shows it 1 clk after the state change.
//   - flash_req outside IDLE is ignored; it does not queue or restart a sequence.
//   - flash_req and startOfFrame in the same IDLE cycle -> ARMED; the flash starts at
//     the next frame.
//   - Full sequence length: 2*BLINK_FRAMES*FLASH_COUNT frames after arming.
//  Widths: frame_cnt = $clog2(BLINK_FRAMES+1) bits; phase_cnt = $clog2(FLASH_COUNT+1) bits.
//   Counters never wrap; reaching zero always triggers the transition.
// STRUCTURE
//  Package layers_pkg:
//   - TRANSPARENT_RGB = 8'hFF
//   - typedef flash_state_t (4-state enum above)
//   - typedef rgb_t = logic [7:0]
//   - named colour constants shared with the object drawers
//  Sub-module flash_timer: holds the FSM and both counters.
//   Ports: clk, resetN, startOfFrame, flash_req -> flash_on, flash_active.
//  Top level: combinational priority encoder, output register, flash_timer instance.
// TESTING
//  1 Reset: hold resetN=0 with random inputs -> RGBOut=00 and flash_active=0 throughout.
//  2 Priority: dr=4'b0110, rgb1=8'h03, rgb2=8'h1C -> RGBOut=03 on the next clk;
//    rgb1=FF -> RGBOut=1C; dr=0, bg=8'h40 -> RGBOut=40.
//  3 Flash: BLINK_FRAMES=2, FLASH_COUNT=2; flash_req, then frames with no layers,
//    bg=8'h40 -> per frame 1F,1F,40,40,1F,1F,40,40 then 40; flash_active high for exactly 8 frames.
//  4 Simultaneous pulses: flash_req with startOfFrame in the same cycle -> ON starts
//    one frame later, not in the current frame.
//  5 Ignored request: flash_req during FLASH_OFF -> sequence length unchanged, no restart.
//  6 Mid-flash reset: resetN low for 1 clk during FLASH_ON -> IDLE; RGBOut=bg one clk
//    after release.

Source files
------------

// File: rtl/layers_pkg.sv
// Shared colour types and constants for the pixel layer mux and object drawers.
// The colour key TRANSPARENT_RGB marks pixels that let lower layers show through.
package layers_pkg;

    typedef logic [7:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        FLASH_ON  = 2'd2,
        FLASH_OFF = 2'd3
    } flash_state_t;

    localparam rgb_t TRANSPARENT_RGB = 8'hFF;

    localparam rgb_t COL_BLACK  = 8'h00;
    localparam rgb_t COL_RED    = 8'hE0;
    localparam rgb_t COL_GREEN  = 8'h1C;
    localparam rgb_t COL_BLUE   = 8'h03;
    localparam rgb_t COL_YELLOW = 8'hFC;
    localparam rgb_t COL_CYAN   = 8'h1F;

    function automatic logic is_opaque(input rgb_t c);
        return c != TRANSPARENT_RGB;
    endfunction

endpackage

// File: rtl/flash_timer.sv
// Goal-flash sequencer: arms on a request, then alternates ON/OFF phases of
// BLINK_FRAMES frames each, FLASH_COUNT times, changing state only at frame start.
module flash_timer
    import layers_pkg::*;
#(
    parameter int BLINK_FRAMES = 8,
    parameter int FLASH_COUNT  = 3
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic flash_req,
    output logic flash_on,
    output logic flash_active
);

    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam int PW = $clog2(FLASH_COUNT + 1);
    localparam logic [FW-1:0] FRAME_RELOAD = FW'(BLINK_FRAMES - 1);
    localparam logic [PW-1:0] PHASE_RELOAD = PW'(FLASH_COUNT - 1);

    flash_state_t state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [PW-1:0] phase_q, phase_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            frame_q <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        phase_d = phase_q;
        unique case (state_q)
            IDLE: begin
                if (flash_req) state_d = ARMED;
            end
            ARMED: begin
                if (startOfFrame) begin
                    state_d = FLASH_ON;
                    frame_d = FRAME_RELOAD;
                    phase_d = PHASE_RELOAD;
                end
            end
            FLASH_ON: begin
                if (startOfFrame) begin
                    if (frame_q != '0) begin
                        frame_d = frame_q - 1'b1;
                    end else begin
                        state_d = FLASH_OFF;
                        frame_d = FRAME_RELOAD;
                    end
                end
            end
            FLASH_OFF: begin
                if (startOfFrame) begin
                    if (frame_q != '0) begin
                        frame_d = frame_q - 1'b1;
                    end else if (phase_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FLASH_ON;
                        phase_d = phase_q - 1'b1;
                        frame_d = FRAME_RELOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign flash_on     = (state_q == FLASH_ON);
    assign flash_active = (state_q == FLASH_ON) || (state_q == FLASH_OFF);

endmodule

// File: rtl/layers_flash_mux.sv
// Final pixel stage: fixed-priority layer mux with colour key over a background
// that blinks to FLASH_RGB during a goal flash; output is registered.
module layers_flash_mux
    import layers_pkg::*;
#(
    parameter int   NUM_LAYERS   = 4,
    parameter int   BLINK_FRAMES = 8,
    parameter int   FLASH_COUNT  = 3,
    parameter rgb_t FLASH_RGB    = 8'h1F
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic                  flash_req,
    input  logic [NUM_LAYERS-1:0] layer_dr,
    input  rgb_t [NUM_LAYERS-1:0] layer_rgb,
    input  rgb_t                  background_rgb,
    output rgb_t                  RGBOut,
    output logic                  flash_active
);

    logic flash_on;
    rgb_t rgb_d, rgb_q;

    flash_timer #(
        .BLINK_FRAMES(BLINK_FRAMES),
        .FLASH_COUNT (FLASH_COUNT)
    ) u_timer (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .flash_req   (flash_req),
        .flash_on    (flash_on),
        .flash_active(flash_active)
    );

    // Scan from lowest priority upward so the lowest opaque index wins.
    always_comb begin
        rgb_d = flash_on ? FLASH_RGB : background_rgb;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_dr[i] && is_opaque(layer_rgb[i])) rgb_d = layer_rgb[i];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) rgb_q <= COL_BLACK;
        else         rgb_q <= rgb_d;
    end

    assign RGBOut = rgb_q;

endmodule

// File: tb/tb_layers_flash_mux.sv
// Directed bench for layers_flash_mux: reset, priority, flash sequencing,
// simultaneous pulses, ignored requests and mid-flash reset.
module tb_layers_flash_mux;
    import layers_pkg::*;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       flash_req;
    logic [3:0] layer_dr;
    rgb_t [3:0] layer_rgb;
    rgb_t       background_rgb;
    rgb_t       RGBOut;
    logic       flash_active;

    int checks   = 0;
    int failures = 0;

    layers_flash_mux #(
        .NUM_LAYERS  (4),
        .BLINK_FRAMES(2),
        .FLASH_COUNT (2),
        .FLASH_RGB   (8'h1F)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .flash_req     (flash_req),
        .layer_dr      (layer_dr),
        .layer_rgb     (layer_rgb),
        .background_rgb(background_rgb),
        .RGBOut        (RGBOut),
        .flash_active  (flash_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One frame: sof for one clk, then three idle clks; sample at the end.
    task automatic frame(input logic req_with_sof);
        @(negedge clk);
        startOfFrame = 1'b1;
        flash_req    = req_with_sof;
        @(negedge clk);
        startOfFrame = 1'b0;
        flash_req    = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_req();
        @(negedge clk);
        flash_req = 1'b1;
        @(negedge clk);
        flash_req = 1'b0;
    endtask

    logic [7:0] exp_seq [9];
    int         act_frames;

    initial begin
        exp_seq = '{8'h1F, 8'h1F, 8'h40, 8'h40, 8'h1F, 8'h1F,
                    8'h40, 8'h40, 8'h40};
        resetN = 1'b0;
        startOfFrame = 1'b0;
        flash_req = 1'b0;
        layer_dr = '0;
        layer_rgb = '0;
        background_rgb = 8'h40;

        // 1: reset with random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            startOfFrame   = 1'($urandom);
            flash_req      = 1'($urandom);
            layer_dr       = 4'($urandom);
            layer_rgb      = 32'($urandom);
            background_rgb = 8'($urandom);
            @(posedge clk);
            #1;
            check("reset_rgb", RGBOut, 8'h00);
            check("reset_active", {7'd0, flash_active}, 8'h00);
        end
        @(negedge clk);
        startOfFrame = 1'b0;
        flash_req = 1'b0;
        layer_dr = '0;
        layer_rgb = '0;
        background_rgb = 8'h40;
        resetN = 1'b1;

        // 2: priority
        @(negedge clk);
        layer_dr = 4'b0110;
        layer_rgb = {8'h77, 8'h1C, 8'h03, 8'h55};
        @(negedge clk);
        check("prio_l1", RGBOut, 8'h03);
        layer_rgb[1] = 8'hFF;
        @(negedge clk);
        check("prio_l1_transp", RGBOut, 8'h1C);
        layer_dr = 4'b0000;
        @(negedge clk);
        check("prio_bg", RGBOut, 8'h40);
        layer_dr = 4'b1001;
        layer_rgb = {8'h77, 8'h1C, 8'h03, 8'hFF};
        @(negedge clk);
        check("prio_l3", RGBOut, 8'h77);
        layer_dr = 4'b1111;
        layer_rgb = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        @(negedge clk);
        check("prio_all_transp", RGBOut, 8'h40);
        layer_dr = 4'b1111;
        layer_rgb = {8'h77, 8'h1C, 8'h03, 8'hE0};
        @(negedge clk);
        check("prio_l0", RGBOut, 8'hE0);
        layer_dr = '0;

        // 3: full flash sequence
        pulse_req();
        act_frames = 0;
        for (int f = 0; f < 9; f++) begin
            frame(1'b0);
            check($sformatf("flash_f%0d", f), RGBOut, exp_seq[f]);
            if (flash_active) act_frames++;
        end
        check("flash_len", 8'(act_frames), 8'd8);

        // 4: simultaneous pulses, plus layer drawn over flash
        frame(1'b1);
        check("simul_no_on", RGBOut, 8'h40);
        check("simul_inactive", {7'd0, flash_active}, 8'h00);
        frame(1'b0);
        check("simul_on", RGBOut, 8'h1F);
        check("simul_active", {7'd0, flash_active}, 8'h01);
        layer_dr = 4'b1000;
        layer_rgb[3] = 8'h55;
        @(negedge clk);
        check("layer_over_flash", RGBOut, 8'h55);
        layer_dr = '0;

        // 6: mid-flash reset
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check("midrst_rgb", RGBOut, 8'h00);
        check("midrst_active", {7'd0, flash_active}, 8'h00);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_bg", RGBOut, 8'h40);
        check("midrst_idle", {7'd0, flash_active}, 8'h00);

        // 5: request during FLASH_OFF is ignored
        pulse_req();
        act_frames = 0;
        for (int f = 0; f < 12; f++) begin
            frame(1'b0);
            if (f == 2) begin
                check("ign_in_off", RGBOut, 8'h40);
                pulse_req();
            end
            if (flash_active) act_frames++;
        end
        check("ign_len", 8'(act_frames), 8'd8);
        check("ign_end_idle", {7'd0, flash_active}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
